// File: rtl/updown_counter_4bit_pkg.sv
// Shared constants and the action decode for the up/down counter.
package updown_counter_4bit_pkg;

    // Default counter width.
    localparam int CNT_W = 4;

    // Direction encoding on the select input.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // What the counter does on the next edge, reset excluded.
    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_LOAD = 2'd1,
        ACT_UP   = 2'd2,
        ACT_DOWN = 2'd3
    } cnt_act_e;

    // Resolve the control inputs into one action.
    // Load beats counting; with no load and no enable the value holds.
    function automatic cnt_act_e decode_action(
        input logic load,
        input logic enable,
        input logic select
    );
        cnt_act_e act;
        if (load) begin
            act = ACT_LOAD;
        end else if (enable) begin
            act = (select == DIR_UP) ? ACT_UP : ACT_DOWN;
        end else begin
            act = ACT_HOLD;
        end
        return act;
    endfunction

endpackage

// File: rtl/updown_counter_4bit_next_state.sv
// Combinational next-count logic: load, count up/down modulo 2^WIDTH, or hold.
// Reset is applied by the register in the top level, not here.
module updown_counter_4bit_next_state
    import updown_counter_4bit_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             enable,
    input  logic             select,
    output logic [WIDTH-1:0] cnt_next
);

    cnt_act_e act;

    assign act = decode_action(load, enable, select);

    // Select the next value; natural WIDTH-bit overflow gives the wrap-around.
    always_comb begin
        cnt_next = cnt;
        unique case (act)
            ACT_LOAD: cnt_next = data;
            ACT_UP:   cnt_next = cnt + WIDTH'(1);
            ACT_DOWN: cnt_next = cnt - WIDTH'(1);
            default:  cnt_next = cnt;
        endcase
    end

endmodule

// File: rtl/updown_counter_4bit.sv
// Synchronous up/down counter with parallel load and count enable.
// Priority on each rising edge: rst, then load, then enable (direction by select).
module updown_counter_4bit
    import updown_counter_4bit_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             enable,
    input  logic             select,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    updown_counter_4bit_next_state #(
        .WIDTH (WIDTH)
    ) u_next_state (
        .cnt      (cnt_q),
        .data     (data),
        .load     (load),
        .enable   (enable),
        .select   (select),
        .cnt_next (cnt_d)
    );

    // Count register; synchronous reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Output comes straight from the register, no path from inputs.
    assign out = cnt_q;

endmodule

// File: tb/tb_updown_counter_4bit.sv
// Self-checking bench for updown_counter_4bit: directed scenarios plus a
// randomized run against an arithmetic reference model.
module tb_updown_counter_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] data;
    logic       load;
    logic       enable;
    logic       select;
    logic [3:0] out;

    int checks = 0;
    int fails  = 0;
    int model  = 0;   // reference count, kept as a plain integer 0..15

    updown_counter_4bit dut (
        .clk    (clk),
        .rst    (rst),
        .data   (data),
        .load   (load),
        .enable (enable),
        .select (select),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish before limit");
        $fatal(1, "watchdog expired");
    end

    // Reference rule: reset to 0, else load, else +/-1 modulo 16, else hold.
    function automatic int ref_step(input int cur, input logic r, input logic l,
                                    input int d, input logic e, input logic s);
        if (r)      return 0;
        if (l)      return d;
        if (!e)     return cur;
        if (!s)     return (cur + 1) % 16;
        return (cur + 15) % 16;
    endfunction

    // Drive one edge's worth of inputs, wait for the edge, sample 1 ns later.
    task automatic tick(input logic r, input logic l, input logic [3:0] d,
                        input logic e, input logic s);
        rst = r; load = l; data = d; enable = e; select = s;
        @(posedge clk);
        model = ref_step(model, r, l, int'(d), e, s);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1, 4'h9, 1'b1, 1'b0);
            checks++;
            if (out !== 4'h0) begin
                fails++;
                $display("FAIL reset edge %0d: got %h expected %h", i, out, 4'h0);
            end
        end
    endtask

    task automatic test_load_up;
        logic [3:0] exp_v [3] = '{4'h5, 4'h6, 4'h7};
        tick(1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
        checks++;
        if (out !== 4'h4) begin
            fails++;
            $display("FAIL load_4: got %h expected %h", out, 4'h4);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
            checks++;
            if (out !== exp_v[i]) begin
                fails++;
                $display("FAIL up_count step %0d: got %h expected %h", i, out, exp_v[i]);
            end
        end
    endtask

    task automatic test_hold_dir;
        logic [3:0] exp_v [2] = '{4'h6, 4'h5};
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 4'hC, 1'b0, 1'(i % 2));
            checks++;
            if (out !== 4'h7) begin
                fails++;
                $display("FAIL hold step %0d: got %h expected %h", i, out, 4'h7);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
            checks++;
            if (out !== exp_v[i]) begin
                fails++;
                $display("FAIL down_after_hold step %0d: got %h expected %h", i, out, exp_v[i]);
            end
        end
    endtask

    task automatic test_wrap;
        logic [3:0] up_v [3] = '{4'hF, 4'h0, 4'h1};
        logic [3:0] dn_v [3] = '{4'h0, 4'hF, 4'hE};
        tick(1'b0, 1'b1, 4'hE, 1'b1, 1'b1);
        checks++;
        if (out !== 4'hE) begin
            fails++;
            $display("FAIL wrap_load_E: got %h expected %h", out, 4'hE);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
            checks++;
            if (out !== up_v[i]) begin
                fails++;
                $display("FAIL wrap_up step %0d: got %h expected %h", i, out, up_v[i]);
            end
        end
        tick(1'b0, 1'b1, 4'h1, 1'b1, 1'b0);
        checks++;
        if (out !== 4'h1) begin
            fails++;
            $display("FAIL wrap_load_1: got %h expected %h", out, 4'h1);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
            checks++;
            if (out !== dn_v[i]) begin
                fails++;
                $display("FAIL wrap_down step %0d: got %h expected %h", i, out, dn_v[i]);
            end
        end
    endtask

    task automatic test_priority;
        tick(1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
        checks++;
        if (out !== 4'h3) begin
            fails++;
            $display("FAIL prio_load_3: got %h expected %h", out, 4'h3);
        end
        tick(1'b0, 1'b1, 4'hA, 1'b1, 1'b0);
        checks++;
        if (out !== 4'hA) begin
            fails++;
            $display("FAIL load_over_enable: got %h expected %h", out, 4'hA);
        end
        tick(1'b1, 1'b1, 4'h5, 1'b1, 1'b0);
        checks++;
        if (out !== 4'h0) begin
            fails++;
            $display("FAIL rst_over_load: got %h expected %h", out, 4'h0);
        end
    endtask

    task automatic test_reset_mid;
        tick(1'b0, 1'b1, 4'h8, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        checks++;
        if (out !== 4'h7) begin
            fails++;
            $display("FAIL mid_down_1: got %h expected %h", out, 4'h7);
        end
        tick(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        checks++;
        if (out !== 4'h6) begin
            fails++;
            $display("FAIL mid_down_2: got %h expected %h", out, 4'h6);
        end
        tick(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
        checks++;
        if (out !== 4'h0) begin
            fails++;
            $display("FAIL mid_reset: got %h expected %h", out, 4'h0);
        end
        tick(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        checks++;
        if (out !== 4'h1) begin
            fails++;
            $display("FAIL resume_after_reset: got %h expected %h", out, 4'h1);
        end
    endtask

    // Random mix of all controls, checked every edge against the model.
    task automatic test_random;
        logic       r, l, e, s;
        logic [3:0] d;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 19) == 0);
            l = ($urandom_range(0, 4) == 0);
            e = ($urandom_range(0, 9) < 7);
            s = 1'($urandom_range(0, 1));
            d = 4'($urandom_range(0, 15));
            tick(r, l, d, e, s);
            checks++;
            if (out !== 4'(model)) begin
                fails++;
                $display("FAIL random cycle %0d (rst=%b load=%b data=%h en=%b sel=%b): got %h expected %h",
                         i, r, l, d, e, s, out, 4'(model));
            end
        end
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; data = 4'h0; enable = 1'b0; select = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_up();
        test_hold_dir();
        test_wrap();
        test_priority();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/updown_counter_4bit.md
Name: updown_counter_4bit

Overview:
- Synchronous 4-bit up/down binary counter with parallel load and count enable.
- Generic datapath utility: counter/timer cores, address stepping, lab-level sequencing.
- Single clock domain; all state updates on the rising edge of clk.

Parameters:
- WIDTH, 4, counter and data width in bits. The block is specified and verified at 4; other values follow the same rules modulo 2^WIDTH.

Ports:
- clk     input   1      rising-edge clock
- rst     input   1      synchronous reset, active-high
- data    input   WIDTH  parallel load value
- load    input   1      synchronous parallel load, active-high
- enable  input   1      count enable, active-high
- select  input   1      direction: 0 = count up, 1 = count down
- out     output  WIDTH  current count, driven directly from the register

Interface decision:
- One clock; reset is synchronous and active-high.
- Clock port is clk; reset port is rst.
- Positional order is clk, rst, data, load, enable, select, out.

Behaviour:
- Single WIDTH-bit register cnt; out = cnt (registered, no combinational path from inputs to out).
- Evaluated on each rising edge of clk, strict priority:
  1. rst = 1: cnt <= 0. All other inputs are ignored.
  2. else load = 1: cnt <= data. enable and select are ignored.
  3. else enable = 1, select = 0: cnt <= cnt + 1, modulo 2^WIDTH.
  4. else enable = 1, select = 1: cnt <= cnt - 1, modulo 2^WIDTH.
  5. else: cnt holds its value.
- Latency: every action is visible on out one edge after it is sampled. No handshake.
- Wrap-around:
  - Up from 4'hF gives 4'h0.
  - Down from 4'h0 gives 4'hF.
  - No terminal-count or carry output.
- Simultaneous events:
  - rst wins over load and enable.
  - load wins over enable.
  - Changing select while enabled takes effect at the next edge, with no dead cycle.
- Reset mid-count: the next edge forces 0 regardless of direction or enable. Counting resumes on the first edge after rst deasserts.
- Power-up value before the first reset edge is undefined. Benches must apply rst or load first.
- No asynchronous behaviour. Inputs are sampled only at clk rising edges.

Decomposition:
- Optional shared package entries:
  - Direction constants DIR_UP = 1'b0 and DIR_DOWN = 1'b1.
  - Default width constant CNT_W = 4.
- No sub-module. A single always block for the register plus next-state logic suffices.
- If partitioned, a combinational next-state helper, updown_next_state, is the natural split. It takes cnt, data, load, enable and select and returns the next value.

Test Plan:
- Reset: rst=1 for 2 edges with load=1, enable=1, data=4'h9 -> out=4'h0 on both edges.
- Load then up count: rst=0, load=1, data=4'h4 for 1 edge -> out=4'h4. Then load=0, enable=1, select=0 for 3 edges -> out 4'h5, 4'h6, 4'h7.
- Hold and direction change:
  - From 4'h7 with enable=0 for 3 edges -> out stays 4'h7.
  - Then enable=1, select=1 for 2 edges -> out 4'h6, 4'h5.
- Wrap-around:
  - Load 4'hE, count up 3 edges -> out 4'hF, 4'h0, 4'h1.
  - Load 4'h1, count down 3 edges -> out 4'h0, 4'hF, 4'hE.
- Priority:
  - At count 4'h3, assert load=1 with data=4'hA, enable=1, select=0 -> out=4'hA, not 4'h4.
  - Next edge assert rst=1 with load=1 -> out=4'h0.
- Reset mid-count: count down from 4'h8, assert rst on the third edge -> out 4'h7, 4'h6, then 4'h0. Deassert rst with select=0, enable=1 -> out 4'h1 on the following edge.
